serial_frame_deserializer: RTL and testbench

- Downstream consumer of the 1011-preamble detector's serial payload stream: takes serial data bits qualified by a valid strobe and assembles each frame into a parallel address + data word.
- Each frame is ADDR_BITS address bits, then DATA_BITS data bits, MSB first.
- The completed word is presented in a one-entry output buffer with a valid/ready handshake.
- Short frames and overflow are flagged, never silently merged.

---
 rtl/serial_frame_pkg.sv | 15 +
 rtl/sipo_shift_reg.sv | 26 ++
 rtl/serial_frame_deserializer.sv | 108 ++++++++++
 tb/tb_serial_frame_deserializer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/serial_frame_pkg.sv
// Shared types and sizing helpers for the serial frame deserializer.
package serial_frame_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, TAIL} frame_state_t;

  function automatic int frame_bits(input int addr_bits, input int data_bits);
    return addr_bits + data_bits;
  endfunction

  // Counter must reach FRAME_BITS itself, hence the +1.
  function automatic int cnt_width(input int addr_bits, input int data_bits);
    return $clog2(addr_bits + data_bits + 1);
  endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in/parallel-out shift register, MSB-first (new bits enter at the LSB).
module sipo_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q
);

  generate
    if (WIDTH == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (rst)           q <= '0;
        else if (shift_en) q <= ser_in;
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (rst)           q <= '0;
        else if (shift_en) q <= {q[WIDTH-2:0], ser_in};
      end
    end
  endgenerate

endmodule

// File: rtl/serial_frame_deserializer.sv
// Assembles MSB-first serial frames into address + data words held in a
// one-entry valid/ready output buffer, flagging short frames and overflow.
module serial_frame_deserializer
  import serial_frame_pkg::*;
#(
  parameter int ADDR_BITS = 2,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serIn,
  input  logic                 serInValid,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [ADDR_BITS-1:0] out_addr,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 err_short,
  output logic                 overflow
);

  localparam int FRAME_BITS = frame_bits(ADDR_BITS, DATA_BITS);
  localparam int CNT_W      = cnt_width(ADDR_BITS, DATA_BITS);

  frame_state_t          state;
  logic [CNT_W-1:0]      cnt;
  logic [FRAME_BITS-2:0] sh_q;
  logic [FRAME_BITS-1:0] word;
  logic                  accept;
  logic                  complete;
  logic                  pop;

  assign accept   = serInValid && (state == IDLE || state == SHIFT);
  assign complete = serInValid && (state == SHIFT) && (cnt == CNT_W'(FRAME_BITS - 1));
  assign pop      = out_valid && out_ready;

  // The register only keeps the first FRAME_BITS-1 bits; the final bit is
  // merged straight from serIn so the word can load on the completing edge.
  sipo_shift_reg #(
    .WIDTH(FRAME_BITS - 1)
  ) u_sipo (
    .clk     (clk),
    .rst     (rst),
    .shift_en(accept),
    .ser_in  (serIn),
    .q       (sh_q)
  );

  assign word = {sh_q, serIn};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      err_short <= 1'b0;
    end else begin
      err_short <= 1'b0;
      case (state)
        IDLE: begin
          if (serInValid) begin
            cnt   <= CNT_W'(1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (serInValid) begin
            cnt <= cnt + CNT_W'(1);
            if (complete) state <= TAIL;
          end else begin
            err_short <= 1'b1;
            cnt       <= '0;
            state     <= IDLE;
          end
        end
        TAIL: begin
          if (!serInValid) begin
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (complete && (!out_valid || pop)) begin
        out_valid <= 1'b1;
        out_addr  <= word[FRAME_BITS-1 -: ADDR_BITS];
        out_data  <= word[DATA_BITS-1:0];
      end else if (complete) begin
        overflow <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Self-checking bench: directed scenarios plus random traffic against a
// run-length based reference model of the frame rules.
module tb_serial_frame_deserializer;

  localparam int AB = 2;
  localparam int DB = 8;
  localparam int FB = AB + DB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          serIn = 1'b0;
  logic          serInValid = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [AB-1:0] out_addr;
  logic [DB-1:0] out_data;
  logic          err_short;
  logic          overflow;

  serial_frame_deserializer #(
    .ADDR_BITS(AB),
    .DATA_BITS(DB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .serIn     (serIn),
    .serInValid(serInValid),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .err_short (err_short),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Reference model state: bits seen in the current valid run and the buffer.
  int            run_len = 0;
  logic [FB-1:0] frame = '0;
  logic          e_valid = 1'b0;
  logic [AB-1:0] e_addr = '0;
  logic [DB-1:0] e_data = '0;
  logic          e_err = 1'b0;
  logic          e_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_step(input logic rs, input logic v, input logic b, input logic r);
    logic done;
    logic pop;
    if (rs) begin
      run_len = 0; frame = '0; e_valid = 0; e_addr = '0; e_data = '0;
      e_err = 0; e_ovf = 0;
      return;
    end
    e_err = 0;
    e_ovf = 0;
    done  = 0;
    pop   = e_valid && r;
    if (v) begin
      if (run_len < FB) begin
        frame = {frame[FB-2:0], b};
        run_len++;
        if (run_len == FB) done = 1;
      end else begin
        run_len++;
      end
    end else begin
      if (run_len > 0 && run_len < FB) e_err = 1;
      run_len = 0;
    end
    if (done) begin
      if (!e_valid || pop) begin
        e_valid = 1;
        e_addr  = frame[FB-1:DB];
        e_data  = frame[DB-1:0];
      end else begin
        e_ovf = 1;
      end
    end else if (pop) begin
      e_valid = 0;
    end
  endtask

  task automatic cyc(input logic v, input logic b, input logic r, input logic rs = 1'b0);
    rst = rs; serInValid = v; serIn = b; out_ready = r;
    @(posedge clk);
    model_step(rs, v, b, r);
    #1;
    check("out_valid", 32'(out_valid), 32'(e_valid));
    check("out_addr",  32'(out_addr),  32'(e_addr));
    check("out_data",  32'(out_data),  32'(e_data));
    check("err_short", 32'(err_short), 32'(e_err));
    check("overflow",  32'(overflow),  32'(e_ovf));
  endtask

  // Sends nbits with valid high (bits beyond FB are random), ready r except
  // r_last on the last bit, then one idle cycle with ready r_gap.
  task automatic run_frame(input logic [FB-1:0] w, input int nbits,
                           input logic r, input logic r_last, input logic r_gap);
    for (int i = 0; i < nbits; i++) begin
      logic bt;
      bt = (i < FB) ? w[FB-1-i] : 1'($urandom_range(0, 1));
      cyc(1'b1, bt, (i == nbits - 1) ? r_last : r);
    end
    cyc(1'b0, 1'b0, r_gap);
  endtask

  initial begin
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);

    run_frame({2'b10, 8'hA5}, FB, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);

    run_frame({2'b11, 8'h3C}, 6, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    run_frame({2'b11, 8'h3C}, FB, 1'b1, 1'b1, 1'b1);

    run_frame({2'b01, 8'h55}, FB, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    run_frame({2'b11, 8'hFF}, FB, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);

    run_frame({2'b00, 8'h11}, FB, 1'b0, 1'b0, 1'b0);
    run_frame({2'b10, 8'h22}, FB, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);

    run_frame({2'b01, 8'h81}, FB + 3, 1'b1, 1'b1, 1'b1);
    run_frame({2'b01, 8'h81}, FB + 3, 1'b1, 1'b1, 1'b1);

    run_frame({2'b10, 8'h77}, FB, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    run_frame({2'b01, 8'hC3}, FB, 1'b1, 1'b1, 1'b1);

    for (int f = 0; f < 150; f++) begin
      int unsigned len;
      int unsigned gap;
      logic [FB-1:0] w;
      len = $urandom_range(1, FB + 3);
      if ($urandom_range(0, 3) != 0) len = FB;
      w   = FB'($urandom);
      for (int i = 0; i < int'(len); i++) begin
        logic bt;
        bt = (i < FB) ? w[FB-1-i] : 1'($urandom_range(0, 1));
        cyc(1'b1, bt, 1'($urandom_range(0, 1)));
      end
      gap = $urandom_range(1, 3);
      for (int g = 0; g < int'(gap); g++)
        cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 40) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
